keypad_multitap_scanner: RTL and testbench



---
 rtl/keypad_multitap_scanner.sv | 220 ++++++++++++++++++++++
 tb/tb_keypad_multitap_scanner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_multitap_scanner.sv
// rtl/keypad_multitap_scanner.sv - matrix keypad scanner with frame debounce and phone-style multi-tap entry
// Optional feature macro: KEYPAD_AUTO_COMMIT_EN (commit pending letter on tap timeout or group change).
module keypad_multitap_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int TAP_TIMEOUT     = 100000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] row_in,
    output logic [COLS-1:0] col_drv,
    output logic [7:0]      letter,
    output logic            letter_pending,
    output logic            commit_valid,
    output logic [7:0]      commit_letter,
    output logic            word_submit,
    output logic            clear,
    output logic            multi_key_err
);
    localparam int NKEYS = ROWS * COLS;
    localparam int KW    = $clog2(NKEYS);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int DW    = $clog2(SCAN_CYCLES + 1);
    localparam int FW    = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int TW    = $clog2(TAP_TIMEOUT + 1);

    typedef enum logic {IDLE, COMPOSE} state_t;

    logic [DW-1:0] dwell;
    logic [CW-1:0] col_idx;
    logic [1:0]    frame_cnt;
    logic [KW-1:0] frame_key;
    logic [FW-1:0] deb_cnt;
    logic          stable_valid;
    logic [KW-1:0] stable_key;
    logic          press_evt;
    logic [KW-1:0] press_key;

    logic          sample, frame_done;
    logic [1:0]    row_pop;
    logic [RW-1:0] row_sel;
    logic [2:0]    pop_sum;
    logic [1:0]    acc_cnt;
    logic [KW-1:0] acc_key;
    logic          cand_valid, cand_same;
    logic [FW-1:0] deb_next;

    assign sample     = (dwell == DW'(SCAN_CYCLES - 1));
    assign frame_done = sample && (col_idx == CW'(COLS - 1));

    // Frame accumulator tracks how many keys were seen (saturating at 2 = MULTI) and the first one.
    always_comb begin
        row_pop = 2'd0;
        row_sel = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (row_in[r]) begin
                row_pop = (row_pop == 2'd2) ? 2'd2 : row_pop + 2'd1;
                row_sel = RW'(r);
            end
        end
        pop_sum    = {1'b0, frame_cnt} + {1'b0, row_pop};
        acc_cnt    = (pop_sum >= 3'd2) ? 2'd2 : pop_sum[1:0];
        acc_key    = (frame_cnt == 2'd0 && row_pop == 2'd1) ?
                     KW'(row_sel) * KW'(COLS) + KW'(col_idx) : frame_key;
        cand_valid = (acc_cnt == 2'd1);
        cand_same  = (cand_valid == stable_valid) && (!cand_valid || acc_key == stable_key);
        deb_next   = deb_cnt + FW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell         <= '0;
            col_idx       <= '0;
            col_drv       <= COLS'(1);
            frame_cnt     <= 2'd0;
            frame_key     <= '0;
            deb_cnt       <= '0;
            stable_valid  <= 1'b0;
            stable_key    <= '0;
            press_evt     <= 1'b0;
            press_key     <= '0;
            multi_key_err <= 1'b0;
        end else begin
            press_evt <= 1'b0;
            if (sample) begin
                dwell   <= '0;
                col_drv <= {col_drv[COLS-2:0], col_drv[COLS-1]};
                col_idx <= frame_done ? '0 : col_idx + CW'(1);
                if (frame_done) begin
                    frame_cnt     <= 2'd0;
                    frame_key     <= '0;
                    multi_key_err <= (acc_cnt == 2'd2);
                    // A MULTI frame leaves both the debounce count and the stable key untouched.
                    if (acc_cnt != 2'd2) begin
                        if (cand_same) begin
                            deb_cnt <= '0;
                        end else if (deb_next == FW'(DEBOUNCE_FRAMES)) begin
                            deb_cnt      <= '0;
                            stable_valid <= cand_valid;
                            stable_key   <= cand_valid ? acc_key : '0;
                            press_evt    <= cand_valid && !stable_valid;
                            press_key    <= acc_key;
                        end else begin
                            deb_cnt <= deb_next;
                        end
                    end
                end else begin
                    frame_cnt <= acc_cnt;
                    frame_key <= acc_key;
                end
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    function automatic logic [7:0] group_char(input logic [2:0] g, input logic [1:0] t);
        logic [7:0] base;
        case (g)
            3'd0:    base = 8'h41;
            3'd1:    base = 8'h44;
            3'd2:    base = 8'h47;
            3'd3:    base = 8'h4A;
            3'd4:    base = 8'h4D;
            3'd5:    base = 8'h50;
            3'd6:    base = 8'h54;
            default: base = 8'h57;
        endcase
        return base + {6'd0, t};
    endfunction

    state_t        state, state_n;
    logic [2:0]    group, group_n;
    logic [1:0]    tap, tap_n, tap_last;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic [7:0]    letter_n, commit_letter_n;
    logic          commit_n, submit_n, clear_n;
    logic          is_letter, is_submit, is_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            group          <= 3'd0;
            tap            <= 2'd0;
            tmo_cnt        <= '0;
            letter         <= 8'h00;
            letter_pending <= 1'b0;
            commit_valid   <= 1'b0;
            commit_letter  <= 8'h00;
            word_submit    <= 1'b0;
            clear          <= 1'b0;
        end else begin
            state          <= state_n;
            group          <= group_n;
            tap            <= tap_n;
            tmo_cnt        <= tmo_n;
            letter         <= letter_n;
            letter_pending <= (state_n == COMPOSE);
            commit_valid   <= commit_n;
            commit_letter  <= commit_letter_n;
            word_submit    <= submit_n;
            clear          <= clear_n;
        end
    end

    always_comb begin
        state_n         = state;
        group_n         = group;
        tap_n           = tap;
        commit_n        = 1'b0;
        commit_letter_n = commit_letter;
        submit_n        = 1'b0;
        clear_n         = 1'b0;
        tmo_n           = (state == COMPOSE && tmo_cnt != TW'(TAP_TIMEOUT)) ? tmo_cnt + TW'(1) : tmo_cnt;
        is_letter       = (press_key < KW'(8));
        is_submit       = (press_key == KW'(NKEYS - 1));
        is_clear        = (press_key == KW'(NKEYS - 2));
        tap_last        = (group == 3'd5 || group == 3'd7) ? 2'd3 : 2'd2;
        if (press_evt) begin
            tmo_n = '0;
            if (is_clear) begin
                clear_n = 1'b1;
                state_n = IDLE;
            end else if (is_submit) begin
                if (state == COMPOSE) begin
                    commit_n        = 1'b1;
                    commit_letter_n = letter;
                    state_n         = IDLE;
                end else begin
                    submit_n = 1'b1;
                end
            end else if (is_letter) begin
                if (state == COMPOSE && press_key[2:0] == group && tmo_cnt < TW'(TAP_TIMEOUT)) begin
                    tap_n = (tap == tap_last) ? 2'd0 : tap + 2'd1;
                end else begin
`ifdef KEYPAD_AUTO_COMMIT_EN
                    if (state == COMPOSE) begin
                        commit_n        = 1'b1;
                        commit_letter_n = letter;
                    end
`endif
                    state_n = COMPOSE;
                    group_n = press_key[2:0];
                    tap_n   = 2'd0;
                end
            end
        end
`ifdef KEYPAD_AUTO_COMMIT_EN
        else if (state == COMPOSE && tmo_cnt == TW'(TAP_TIMEOUT)) begin
            commit_n        = 1'b1;
            commit_letter_n = letter;
            state_n         = IDLE;
        end
`endif
        letter_n = (state_n == COMPOSE) ? group_char(group_n, tap_n) : 8'h00;
    end
endmodule

// File: tb/tb_keypad_multitap_scanner.sv
// tb/tb_keypad_multitap_scanner.sv - directed self-checking bench for keypad_multitap_scanner
module tb_keypad_multitap_scanner;
    localparam int FRAME = 8;
`ifdef KEYPAD_AUTO_COMMIT_EN
    localparam int AUTO = 1;
`else
    localparam int AUTO = 0;
`endif

    logic        tb_clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_drv;
    logic [7:0]  letter;
    logic        letter_pending;
    logic        commit_valid;
    logic [7:0]  commit_letter;
    logic        word_submit;
    logic        clear;
    logic        multi_key_err;
    logic [15:0] keys;

    int total = 0;
    int bad = 0;
    int n_commit = 0;
    int n_submit = 0;
    int n_clear = 0;
    logic [7:0] last_commit = 8'h00;

    always #5 tb_clk = ~tb_clk;

    keypad_multitap_scanner #(
        .ROWS(4), .COLS(4), .SCAN_CYCLES(2), .DEBOUNCE_FRAMES(2), .TAP_TIMEOUT(60)
    ) dut (
        .clk(tb_clk),
        .rst(rst),
        .row_in(row_in),
        .col_drv(col_drv),
        .letter(letter),
        .letter_pending(letter_pending),
        .commit_valid(commit_valid),
        .commit_letter(commit_letter),
        .word_submit(word_submit),
        .clear(clear),
        .multi_key_err(multi_key_err)
    );

    // Keypad matrix model: a row reads 1 when a pressed key sits in the driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) row_in[r] = |(keys[r*4 +: 4] & col_drv);
    end

    always @(negedge tb_clk) begin
        if (commit_valid) begin
            n_commit++;
            last_commit = commit_letter;
        end
        if (word_submit) n_submit++;
        if (clear) n_clear++;
    end

    task automatic sync_frame();
        logic [3:0] prev;
        int n;
        prev = col_drv;
        n = 0;
        @(negedge tb_clk);
        while (!(col_drv == 4'b0001 && prev != 4'b0001) && n < 40) begin
            prev = col_drv;
            @(negedge tb_clk);
            n++;
        end
        if (n >= 40) begin
            bad++;
            total++;
            $display("FAIL sync_frame: col_drv=%b never returned to column 0", col_drv);
        end
    endtask

    task automatic press(input logic [15:0] mask, input int frames);
        sync_frame();
        keys = mask;
        repeat (frames * FRAME) @(negedge tb_clk);
        keys = 16'h0;
    endtask

    task automatic idle_frames(input int frames);
        repeat (frames * FRAME) @(negedge tb_clk);
    endtask

    task automatic tap(input int k);
        press(16'h1 << k, 2);
        idle_frames(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        keys = 16'h0;
        repeat (3) @(posedge tb_clk);
        @(negedge tb_clk);
        total++; if (col_drv !== 4'b0001) begin bad++; $display("FAIL reset_col_drv: got %b expected 0001", col_drv); end
        total++; if (letter !== 8'h00) begin bad++; $display("FAIL reset_letter: got %h expected 00", letter); end
        total++; if ({letter_pending, commit_valid, word_submit, clear, multi_key_err} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b expected 00000", {letter_pending, commit_valid, word_submit, clear, multi_key_err});
        end
        total++; if (commit_letter !== 8'h00) begin bad++; $display("FAIL reset_commit_letter: got %h expected 00", commit_letter); end
        rst = 1'b0;
        @(negedge tb_clk);
        total++; if (col_drv !== 4'b0001) begin bad++; $display("FAIL rotate_dwell: got %b expected 0001", col_drv); end
        @(negedge tb_clk);
        total++; if (col_drv !== 4'b0010) begin bad++; $display("FAIL rotate_col1: got %b expected 0010", col_drv); end
        repeat (2) @(negedge tb_clk);
        total++; if (col_drv !== 4'b0100) begin bad++; $display("FAIL rotate_col2: got %b expected 0100", col_drv); end
    endtask

    task automatic test_single_letter();
        int c0, s0;
        c0 = n_commit;
        s0 = n_submit;
        tap(0);
        total++; if (letter !== 8'h41) begin bad++; $display("FAIL single_letter: got %h expected 41", letter); end
        total++; if (letter_pending !== 1'b1) begin bad++; $display("FAIL single_pending: got %b expected 1", letter_pending); end
        tap(15);
        total++; if (n_commit - c0 !== 1) begin bad++; $display("FAIL single_commit_count: got %0d expected 1", n_commit - c0); end
        total++; if (last_commit !== 8'h41) begin bad++; $display("FAIL single_commit_letter: got %h expected 41", last_commit); end
        total++; if (letter !== 8'h00) begin bad++; $display("FAIL single_letter_cleared: got %h expected 00", letter); end
        total++; if (n_submit - s0 !== 0) begin bad++; $display("FAIL single_no_word_submit: got %0d expected 0", n_submit - s0); end
    endtask

    task automatic test_multitap_wrap();
        logic [7:0] exp_seq [5];
        int k0;
        exp_seq[0] = 8'h50; exp_seq[1] = 8'h51; exp_seq[2] = 8'h52; exp_seq[3] = 8'h53; exp_seq[4] = 8'h50;
        for (int i = 0; i < 5; i++) begin
            tap(5);
            total++; if (letter !== exp_seq[i]) begin bad++; $display("FAIL multitap_%0d: got %h expected %h", i, letter, exp_seq[i]); end
        end
        k0 = n_clear;
        tap(14);
        total++; if (n_clear - k0 !== 1) begin bad++; $display("FAIL multitap_clear: got %0d expected 1", n_clear - k0); end
        total++; if (letter !== 8'h00) begin bad++; $display("FAIL multitap_cleared: got %h expected 00", letter); end
    endtask

    task automatic test_timeout();
        int c0;
        logic [7:0] exp_after;
        c0 = n_commit;
        tap(2);
        total++; if (letter !== 8'h47) begin bad++; $display("FAIL timeout_first: got %h expected 47", letter); end
        repeat (100) @(negedge tb_clk);
        exp_after = (AUTO != 0) ? 8'h00 : 8'h47;
        total++; if (letter !== exp_after) begin bad++; $display("FAIL timeout_wait_letter: got %h expected %h", letter, exp_after); end
        tap(2);
        total++; if (letter !== 8'h47) begin bad++; $display("FAIL timeout_no_advance: got %h expected 47", letter); end
        total++; if (n_commit - c0 !== AUTO) begin bad++; $display("FAIL timeout_commits: got %0d expected %0d", n_commit - c0, AUTO); end
        tap(14);
    endtask

    task automatic test_submit_and_clear();
        int c0, s0, k0;
        c0 = n_commit;
        s0 = n_submit;
        k0 = n_clear;
        tap(15);
        total++; if (n_submit - s0 !== 1) begin bad++; $display("FAIL empty_submit: got %0d expected 1", n_submit - s0); end
        tap(3);
        total++; if (letter !== 8'h4A) begin bad++; $display("FAIL clear_pending: got %h expected 4a", letter); end
        tap(14);
        total++; if (n_clear - k0 !== 1) begin bad++; $display("FAIL clear_pulse: got %0d expected 1", n_clear - k0); end
        total++; if (letter !== 8'h00 || letter_pending !== 1'b0) begin
            bad++; $display("FAIL clear_letter: got %h/%b expected 00/0", letter, letter_pending);
        end
        total++; if (n_commit - c0 !== 0) begin bad++; $display("FAIL clear_no_commit: got %0d expected 0", n_commit - c0); end
    endtask

    task automatic test_glitch_multi();
        int c0, s0, k0;
        c0 = n_commit;
        s0 = n_submit;
        k0 = n_clear;
        press(16'h0002, 1);
        idle_frames(2);
        total++; if (letter !== 8'h00 || letter_pending !== 1'b0) begin
            bad++; $display("FAIL glitch_ignored: got %h/%b expected 00/0", letter, letter_pending);
        end
        press(16'h0003, 3);
        total++; if (multi_key_err !== 1'b1) begin bad++; $display("FAIL multi_err_set: got %b expected 1", multi_key_err); end
        total++; if (letter !== 8'h00) begin bad++; $display("FAIL multi_no_letter: got %h expected 00", letter); end
        idle_frames(2);
        total++; if (multi_key_err !== 1'b0) begin bad++; $display("FAIL multi_err_clear: got %b expected 0", multi_key_err); end
        total++; if ((n_commit - c0) + (n_submit - s0) + (n_clear - k0) !== 0) begin
            bad++; $display("FAIL multi_no_events: got %0d expected 0", (n_commit - c0) + (n_submit - s0) + (n_clear - k0));
        end
        total++; if (letter !== 8'h00) begin bad++; $display("FAIL multi_after_release: got %h expected 00", letter); end
    endtask

    task automatic test_reset_mid_compose();
        int c0;
        tap(4);
        total++; if (letter !== 8'h4D) begin bad++; $display("FAIL midrst_compose: got %h expected 4d", letter); end
        c0 = n_commit;
        rst = 1'b1;
        @(negedge tb_clk);
        total++; if (letter !== 8'h00 || letter_pending !== 1'b0 || col_drv !== 4'b0001) begin
            bad++; $display("FAIL midrst_values: got %h/%b/%b expected 00/0/0001", letter, letter_pending, col_drv);
        end
        rst = 1'b0;
        idle_frames(2);
        total++; if (n_commit - c0 !== 0) begin bad++; $display("FAIL midrst_no_commit: got %0d expected 0", n_commit - c0); end
    endtask

    initial begin
        rst = 1'b1;
        keys = 16'h0;
        test_reset();
        test_single_letter();
        test_multitap_wrap();
        test_timeout();
        test_submit_and_clear();
        test_glitch_multi();
        test_reset_mid_compose();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
